// File: rtl/cp2_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp2_issue_unit
// Description : CPU-side initiator for the CP2 task-scheduling coprocessor.
//               Takes one CP2 instruction at a time, issues it to the CP2
//               decode stage, retries while CP2 does not accept it, and
//               returns data/status over a valid/ready response channel.
//               Optional statistics counters: define CP2_ISSUE_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

// CP2 fmt field encodings (instruction bits [25:21]); overridable by the
// surrounding build if the ISA map differs.
`ifndef MFC2_FMT
`define MFC2_FMT      5'b00000
`endif
`ifndef MTC2_FMT
`define MTC2_FMT      5'b00100
`endif
`ifndef MTC2TC_FMT
`define MTC2TC_FMT    5'b00101
`endif
`ifndef TINIT_FMT
`define TINIT_FMT     5'b10000
`endif
`ifndef TDEL_FMT
`define TDEL_FMT      5'b10001
`endif
`ifndef TTTASK_FMT
`define TTTASK_FMT    5'b10010
`endif
`ifndef DISTTTASK_FMT
`define DISTTTASK_FMT 5'b10011
`endif
`ifndef CHTS
`define CHTS          5'b10100
`endif
`ifndef CYTASK
`define CYTASK        5'b10101
`endif

module cp2_issue_unit #(
  parameter int MAX_RETRY = 4,
  parameter int RETRY_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_instruction,
  output logic        cpu_ready,
  input  logic        cpu_flush,
  output logic        cpu_rvalid,
  input  logic        cpu_rready,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_err,
  output logic [31:0] cp2_instruction,
  output logic        cp2_decode_en,
  input  logic        decode_as,
  input  logic        decode_fs,
  input  logic        decode_ts,
  input  logic [31:0] decode_fdata,
  output logic [15:0] stat_retry_cnt,
  output logic [15:0] stat_timeout_cnt
);

  // One-hot class encoding, bit order matches {decode_as, decode_ts, decode_fs}
  localparam logic [2:0] c_cls_none = 3'b000;
  localparam logic [2:0] c_cls_fs   = 3'b001;
  localparam logic [2:0] c_cls_ts   = 3'b010;
  localparam logic [2:0] c_cls_as   = 3'b100;

  localparam logic [1:0] c_err_ok      = 2'b00;
  localparam logic [1:0] c_err_timeout = 2'b01;
  localparam logic [1:0] c_err_illegal = 2'b10;

  localparam logic [RETRY_W-1:0] c_max_retry = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_instr;
  logic [2:0]         r_cls;
  logic [RETRY_W-1:0] r_retry;
  logic               r_ready;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic [1:0]         r_err;

  logic [4:0]         w_fmt;
  logic [2:0]         w_cls;
  logic               w_legal;
  logic               w_hit;
  logic               w_at_limit;

  // Classify the incoming instruction by its fmt field
  always_comb begin
    w_fmt = cpu_instruction[25:21];
    w_cls = c_cls_none;
    case (w_fmt)
      `MFC2_FMT:                      w_cls = c_cls_fs;
      `MTC2_FMT, `MTC2TC_FMT:         w_cls = c_cls_ts;
      `TINIT_FMT, `TDEL_FMT,
      `TTTASK_FMT, `DISTTTASK_FMT,
      `CHTS, `CYTASK:                 w_cls = c_cls_as;
      default:                        w_cls = c_cls_none;
    endcase
    w_legal = (w_cls != c_cls_none);
  end

  // Only the flag of the latched class counts as acceptance
  assign w_hit      = |(r_cls & {decode_as, decode_ts, decode_fs});
  assign w_at_limit = (r_retry == c_max_retry);

  // Decode enable is gated combinationally by flush so a flushed issue never reaches CP2
  assign cp2_decode_en   = (r_state == S_ISSUE) && !cpu_flush;
  assign cp2_instruction = r_instr;
  assign cpu_ready       = r_ready;
  assign cpu_rvalid      = r_rvalid;
  assign cpu_rdata       = r_rdata;
  assign cpu_err         = r_err;

  // Issue/check/response sequencing with registered CPU-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_instr  <= 32'd0;
      r_cls    <= c_cls_none;
      r_retry  <= '0;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= c_err_ok;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req && !cpu_flush) begin
            r_ready <= 1'b0;
            if (w_legal) begin
              r_instr <= cpu_instruction;
              r_cls   <= w_cls;
              r_retry <= '0;
              r_state <= S_ISSUE;
            end else begin
              // Illegal fmt: answer directly without touching CP2
              r_rdata  <= 32'd0;
              r_err    <= c_err_illegal;
              r_rvalid <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          if (cpu_flush) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cpu_flush) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_hit) begin
            // ts-class ops return no data
            r_rdata  <= (r_cls == c_cls_ts) ? 32'd0 : decode_fdata;
            r_err    <= c_err_ok;
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
          end else if (w_at_limit) begin
            r_rdata  <= 32'd0;
            r_err    <= c_err_timeout;
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_ISSUE;
          end
        end

        S_RESP: begin
          if (cpu_flush || cpu_rready) begin
            r_rvalid <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_rvalid <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CP2_ISSUE_STAT_EN
  logic        w_retry_evt;
  logic        w_timeout_evt;
  logic [15:0] r_stat_retry;
  logic [15:0] r_stat_timeout;

  assign w_retry_evt   = (r_state == S_CHECK) && !cpu_flush && !w_hit && !w_at_limit;
  assign w_timeout_evt = (r_state == S_CHECK) && !cpu_flush && !w_hit &&  w_at_limit;

  // Saturating retry/timeout statistics, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_retry   <= 16'd0;
      r_stat_timeout <= 16'd0;
    end else begin
      if (w_retry_evt && (r_stat_retry != 16'hFFFF)) begin
        r_stat_retry <= r_stat_retry + 16'd1;
      end
      if (w_timeout_evt && (r_stat_timeout != 16'hFFFF)) begin
        r_stat_timeout <= r_stat_timeout + 16'd1;
      end
    end
  end

  assign stat_retry_cnt   = r_stat_retry;
  assign stat_timeout_cnt = r_stat_timeout;
`else
  assign stat_retry_cnt   = 16'd0;
  assign stat_timeout_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp2_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp2_issue_unit
// Description : Self-checking bench for cp2_issue_unit: directed scenarios
//               followed by randomized transactions against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MFC2_FMT
`define MFC2_FMT      5'b00000
`endif
`ifndef MTC2_FMT
`define MTC2_FMT      5'b00100
`endif
`ifndef MTC2TC_FMT
`define MTC2TC_FMT    5'b00101
`endif
`ifndef TINIT_FMT
`define TINIT_FMT     5'b10000
`endif
`ifndef TDEL_FMT
`define TDEL_FMT      5'b10001
`endif
`ifndef TTTASK_FMT
`define TTTASK_FMT    5'b10010
`endif
`ifndef DISTTTASK_FMT
`define DISTTTASK_FMT 5'b10011
`endif
`ifndef CHTS
`define CHTS          5'b10100
`endif
`ifndef CYTASK
`define CYTASK        5'b10101
`endif

module tb_cp2_issue_unit;

  localparam int MAX_RETRY = 4;
  localparam int RETRY_W   = 3;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_instruction;
  logic        cpu_ready;
  logic        cpu_flush;
  logic        cpu_rvalid;
  logic        cpu_rready;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_err;
  logic [31:0] cp2_instruction;
  logic        cp2_decode_en;
  logic        decode_as;
  logic        decode_fs;
  logic        decode_ts;
  logic [31:0] decode_fdata;
  logic [15:0] stat_retry_cnt;
  logic [15:0] stat_timeout_cnt;

  cp2_issue_unit #(.MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req          (cpu_req),
    .cpu_instruction  (cpu_instruction),
    .cpu_ready        (cpu_ready),
    .cpu_flush        (cpu_flush),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rready       (cpu_rready),
    .cpu_rdata        (cpu_rdata),
    .cpu_err          (cpu_err),
    .cp2_instruction  (cp2_instruction),
    .cp2_decode_en    (cp2_decode_en),
    .decode_as        (decode_as),
    .decode_fs        (decode_fs),
    .decode_ts        (decode_ts),
    .decode_fdata     (decode_fdata),
    .stat_retry_cnt   (stat_retry_cnt),
    .stat_timeout_cnt (stat_timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int m_retry = 0;
  int m_timeout = 0;

  // Class membership lists, one-hot result order {as, ts, fs}
  logic [4:0] fs_fmts [1] = '{`MFC2_FMT};
  logic [4:0] ts_fmts [2] = '{`MTC2_FMT, `MTC2TC_FMT};
  logic [4:0] as_fmts [6] = '{`TINIT_FMT, `TDEL_FMT, `TTTASK_FMT,
                              `DISTTTASK_FMT, `CHTS, `CYTASK};

  // Count decode enables actually presented to CP2 at each clock edge
  always @(posedge clk) begin
    if (cp2_decode_en === 1'b1) pulse_cnt++;
  end

  function automatic logic [2:0] ref_class(input logic [4:0] fmt);
    logic [2:0] c;
    c = 3'b000;
    foreach (fs_fmts[i]) if (fs_fmts[i] == fmt) c = 3'b001;
    foreach (ts_fmts[i]) if (ts_fmts[i] == fmt) c = 3'b010;
    foreach (as_fmts[i]) if (as_fmts[i] == fmt) c = 3'b100;
    return c;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] fmt);
    logic [31:0] w;
    w = $urandom;
    w[25:21] = fmt;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef CP2_ISSUE_STAT_EN
    check("stat_retry", {16'd0, stat_retry_cnt}, m_retry);
    check("stat_timeout", {16'd0, stat_timeout_cnt}, m_timeout);
`else
    check("stat_retry", {16'd0, stat_retry_cnt}, 32'd0);
    check("stat_timeout", {16'd0, stat_timeout_cnt}, 32'd0);
`endif
  endtask

  task automatic set_flags(input logic [2:0] f);
    {decode_as, decode_ts, decode_fs} = f;
  endtask

  // One complete transaction. CP2 rejects the first n_reject attempts
  // (presenting only foreign-class flags from 'wrong'), then accepts.
  task automatic do_txn(input logic [31:0] instr, input int n_reject,
                        input logic [2:0] wrong, input logic [31:0] fdata,
                        input int hold);
    logic [2:0]  cls;
    logic [31:0] exp_rdata;
    logic [31:0] exp_err;
    int          attempts;
    int          p0;
    bit          timeout;
    cls = ref_class(instr[25:21]);
    @(negedge clk);
    check("idle_ready", {31'd0, cpu_ready}, 1);
    check("idle_rvalid", {31'd0, cpu_rvalid}, 0);
    p0 = pulse_cnt;
    cpu_req = 1'b1;
    cpu_instruction = instr;
    attempts = 0;
    if (cls == 3'b000) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_instruction = $urandom;
      exp_err = 2;
      exp_rdata = 0;
    end else begin
      timeout  = (n_reject > MAX_RETRY);
      attempts = timeout ? MAX_RETRY + 1 : n_reject + 1;
      for (int a = 0; a < attempts; a++) begin
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_instruction = $urandom;
        set_flags(3'b000);
        check("issue_en", {31'd0, cp2_decode_en}, 1);
        check("issue_instr", cp2_instruction, instr);
        check("issue_rvalid", {31'd0, cpu_rvalid}, 0);
        @(negedge clk);
        check("check_en", {31'd0, cp2_decode_en}, 0);
        check("check_rvalid", {31'd0, cpu_rvalid}, 0);
        if (a == n_reject) begin
          set_flags(cls);
          decode_fdata = fdata;
        end else begin
          set_flags(wrong & ~cls);
          decode_fdata = $urandom;
        end
      end
      @(negedge clk);
      exp_err   = timeout ? 1 : 0;
      exp_rdata = (timeout || cls == 3'b010) ? 32'd0 : fdata;
      m_retry  += attempts - 1;
      if (timeout) m_timeout++;
    end
    set_flags(3'b000);
    decode_fdata = $urandom;
    check("resp_rvalid", {31'd0, cpu_rvalid}, 1);
    check("resp_rdata", cpu_rdata, exp_rdata);
    check("resp_err", {30'd0, cpu_err}, exp_err);
    check("resp_en", {31'd0, cp2_decode_en}, 0);
    check("resp_pulses", pulse_cnt - p0, attempts);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      decode_fdata = $urandom;
      check("hold_rvalid", {31'd0, cpu_rvalid}, 1);
      check("hold_rdata", cpu_rdata, exp_rdata);
      check("hold_err", {30'd0, cpu_err}, exp_err);
    end
    cpu_rready = 1'b1;
    @(negedge clk);
    cpu_rready = 1'b0;
    check("done_rvalid", {31'd0, cpu_rvalid}, 0);
    check("done_ready", {31'd0, cpu_ready}, 1);
    check_stats();
  endtask

  logic [4:0]  legal_fmts [9] = '{`MFC2_FMT, `MTC2_FMT, `MTC2TC_FMT, `TINIT_FMT,
                                  `TDEL_FMT, `TTTASK_FMT, `DISTTTASK_FMT,
                                  `CHTS, `CYTASK};
  logic [4:0]  fmt;
  logic [31:0] ins;
  int          p_save;

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_instruction = 32'd0;
    cpu_flush = 1'b0;
    cpu_rready = 1'b0;
    set_flags(3'b000);
    decode_fdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cpu_ready}, 1);
    check("rst_rvalid", {31'd0, cpu_rvalid}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", {30'd0, cpu_err}, 0);
    check("rst_instr", cp2_instruction, 0);
    check("rst_en", {31'd0, cp2_decode_en}, 0);
    check_stats();
    rst = 1'b0;

    // MFC2 accepted first time, fs data returned
    do_txn(mk_instr(`MFC2_FMT), 0, 3'b000, 32'h0000_1234, 0);
    // as-class returns data; ts-class returns zero
    do_txn(mk_instr(`TTTASK_FMT), 0, 3'b000, 32'h0000_0001, 0);
    do_txn(mk_instr(`MTC2_FMT), 0, 3'b000, 32'hDEAD_BEEF, 0);
    // Two rejects then accept
    do_txn(mk_instr(`MFC2_FMT), 2, 3'b000, 32'hCAFE_0002, 1);
    // Never accepted: timeout, response held while rready low
    do_txn(mk_instr(`MTC2_FMT), 10, 3'b101, 32'h0, 3);
    // Illegal fmt
    do_txn(mk_instr(5'b01111), 0, 3'b000, 32'h0, 1);
    // fs flag on an as-class op is a reject
    do_txn(mk_instr(`CHTS), 1, 3'b001, 32'h5555_AAAA, 0);

    // Flush in ISSUE: no decode enable, back to idle, no response
    @(negedge clk);
    p_save = pulse_cnt;
    cpu_req = 1'b1;
    cpu_instruction = mk_instr(`TINIT_FMT);
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_flush = 1'b1;
    #1;
    check("flush_issue_en", {31'd0, cp2_decode_en}, 0);
    @(negedge clk);
    cpu_flush = 1'b0;
    check("flush_issue_ready", {31'd0, cpu_ready}, 1);
    check("flush_issue_rvalid", {31'd0, cpu_rvalid}, 0);
    @(negedge clk);
    check("flush_issue_rvalid2", {31'd0, cpu_rvalid}, 0);
    check("flush_issue_pulses", pulse_cnt - p_save, 0);

    // Flush in IDLE blocks acceptance
    cpu_req = 1'b1;
    cpu_flush = 1'b1;
    cpu_instruction = mk_instr(`MFC2_FMT);
    @(negedge clk);
    check("flush_idle_ready", {31'd0, cpu_ready}, 1);
    check("flush_idle_en", {31'd0, cp2_decode_en}, 0);
    cpu_req = 1'b0;
    cpu_flush = 1'b0;

    // Flush in RESP drops the response
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_instruction = mk_instr(5'b11111);
    @(negedge clk);
    cpu_req = 1'b0;
    check("flush_resp_rvalid_pre", {31'd0, cpu_rvalid}, 1);
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_flush = 1'b0;
    check("flush_resp_rvalid", {31'd0, cpu_rvalid}, 0);
    check("flush_resp_ready", {31'd0, cpu_ready}, 1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) fmt = 5'($urandom);
      else fmt = legal_fmts[$urandom_range(0, 8)];
      do_txn(mk_instr(fmt), int'($urandom_range(0, 6)), 3'($urandom),
             $urandom, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while in CHECK
    @(negedge clk);
    ins = mk_instr(`MTC2TC_FMT);
    cpu_req = 1'b1;
    cpu_instruction = ins;
    @(negedge clk);
    cpu_req = 1'b0;
    check("prerst_instr", cp2_instruction, ins);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_retry = 0;
    m_timeout = 0;
    check("arst_ready", {31'd0, cpu_ready}, 1);
    check("arst_rvalid", {31'd0, cpu_rvalid}, 0);
    check("arst_rdata", cpu_rdata, 0);
    check("arst_err", {30'd0, cpu_err}, 0);
    check("arst_instr", cp2_instruction, 0);
    check("arst_en", {31'd0, cp2_decode_en}, 0);
    check_stats();
    #2;
    rst = 1'b0;

    // Normal operation resumes after reset
    do_txn(mk_instr(`CYTASK), 1, 3'b010, 32'h0BAD_F00D, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp2_issue_unit.md
Name: cp2_issue_unit

Overview:
CPU-side initiator for the CP2 task-scheduling coprocessor. It accepts one CP2 instruction at a time from the main pipeline and drives the CP2 decode stage's instruction bus and decode enable. It then watches the registered decode_as/decode_fs/decode_ts response, retries when CP2 does not accept the instruction, and returns read data and status to the CPU under a valid/ready handshake.

Parameters:
MAX_RETRY, 4, number of re-issues after the first attempt before a timeout error is reported.
RETRY_W, 3, width of the retry counter; must satisfy 2^RETRY_W > MAX_RETRY.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high (`RESET_ENABLE = 1, `RESET_EDGE = posedge)
cpu_req  input  1  CPU presents a CP2 instruction
cpu_instruction  input  32  CP2 instruction word; fmt is [25:21]
cpu_ready  output  1  unit idle and able to accept a request
cpu_flush  input  1  pipeline flush; aborts any in-flight request
cpu_rvalid  output  1  response valid
cpu_rready  input  1  CPU consumes the response
cpu_rdata  output  32  returned data
cpu_err  output  2  00 ok, 01 timeout, 10 illegal fmt
cp2_instruction  output  32  instruction to the CP2 decode stage
cp2_decode_en  output  1  decode enable to CP2
decode_as  input  1  CP2 accepted an as-class op (registered)
decode_fs  input  1  CP2 accepted an fs-class op (registered)
decode_ts  input  1  CP2 accepted a ts-class op (registered)
decode_fdata  input  32  CP2 result data for as/fs ops
stat_retry_cnt  output  16  retry statistics (optional feature)
stat_timeout_cnt  output  16  timeout statistics (optional feature)

Behaviour:
- Reset: state IDLE; cpu_ready=1; cpu_rvalid=0; cpu_rdata=0; cpu_err=00; cp2_instruction=0; cp2_decode_en=0; retry counter=0; stat counters=0.
- Class decode on cpu_instruction fmt:
  - `MFC2_FMT: class fs.
  - `MTC2_FMT and `MTC2TC_FMT: class ts.
  - `TINIT_FMT, `TDEL_FMT, `TTTASK_FMT, `DISTTTASK_FMT, `CHTS, `CYTASK: class as.
  - Any other fmt: illegal.
- FSM states: IDLE, ISSUE, CHECK, RESP.
- IDLE:
  - cpu_ready=1.
  - cpu_req with a legal fmt: latch the instruction and its class, clear the retry counter, go to ISSUE.
  - cpu_req with an illegal fmt: go to RESP with cpu_err=10 and cpu_rdata=0; nothing is issued to CP2.
- ISSUE:
  - cp2_decode_en = ~cpu_flush (combinational).
  - cp2_instruction holds the latched word, stable for the whole cycle.
  - Next state CHECK.
- CHECK:
  - decode_* now reflect the issue made in the previous cycle.
  - If the flag of the latched class is 1:
    - fs or as: cpu_rdata <= decode_fdata.
    - ts: cpu_rdata <= 0.
    - cpu_err <= 00; go to RESP.
  - Else, if retry counter == MAX_RETRY: cpu_err <= 01, cpu_rdata <= 0, go to RESP.
  - Else: increment the retry counter and go to ISSUE.
  - A flag for a different class is ignored and treated as not accepted.
- RESP:
  - cpu_rvalid=1; cpu_rdata and cpu_err are held stable.
  - On cpu_rready: go to IDLE; cpu_rvalid falls on the same edge.
- Outside ISSUE: cp2_decode_en=0; cp2_instruction keeps its last value.
- Latency, no retries: accept at edge E0, decode_en high during E0–E1, CHECK during E1–E2, cpu_rvalid high from E2. That is 2 cycles from accept to response; each retry adds 2 cycles.
- cpu_flush:
  - In ISSUE, CHECK or RESP: go to IDLE at the next edge, no response, cpu_rvalid=0, and no decode_en in the flushed cycle.
  - In IDLE: the request is not accepted that cycle.
- Reset mid-operation: immediate return to reset values; any pending CP2 issue is dropped.

Optional Feature:
Macro CP2_ISSUE_STAT_EN.
- Defined:
  - stat_retry_cnt increments once per retry, i.e. each CHECK→ISSUE transition.
  - stat_timeout_cnt increments once per err=01 response.
  - Both saturate at 16'hFFFF and are cleared only by rst.
- Not defined: both outputs are tied to 0 and no counter logic is built. The port list is identical either way.

Test Plan:
1. MFC2 instruction with decode_fs=1 and decode_fdata=32'h0000_1234 in CHECK -> cpu_rvalid at E2, cpu_rdata=32'h1234, cpu_err=00, exactly one decode_en pulse.
2. TTTASK instruction with decode_as=1 and decode_fdata=1 -> cpu_rdata=1, err=00; MTC2 with decode_ts=1 -> cpu_rdata=0, err=00.
3. MFC2 with decode_fs held 0 for 2 CHECKs, then 1 -> 3 decode_en pulses 2 cycles apart, err=00, stat_retry_cnt=2 (macro on).
4. decode_ts never asserted with MAX_RETRY=4 -> 5 decode_en pulses, then err=01, rdata=0, stat_timeout_cnt=1; cpu_rready held low 3 cycles -> rvalid and data stay stable.
5. fmt not in any class -> no decode_en, rvalid one cycle after accept, err=10; a decode_fs-only flag on an as-class op -> retry, not success.
6. cpu_flush asserted in ISSUE -> decode_en=0 that cycle, IDLE next, no rvalid; async rst pulse in CHECK -> all outputs at reset values immediately, cpu_ready=1.
